// File: rtl/daq_readout_pkg.sv
// Shared types and constants for the Microroc readout path.
package daq_readout_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      READ,
      FLUSH,
      DONE
   } state_e;

   localparam int WORD_W        = 16;
   localparam int TIMEOUT_SHIFT = 8;
   localparam int TIMER_W       = WORD_W + TIMEOUT_SHIFT;
   localparam int BITCNT_W      = $clog2(WORD_W) + 1;

   // Moves the n most recent bits to the top of the word, zero-filling below.
   function automatic logic [WORD_W-1:0] leftAlign(input logic [WORD_W-1:0] bits,
                                                   input logic [BITCNT_W-1:0] n);
      logic [BITCNT_W-1:0] sh;
      sh = BITCNT_W'(WORD_W) - n;
      return bits << sh;
   endfunction

endpackage

// File: rtl/readout_clk_gen.sv
// Enable-gated divider producing READ_CLK (high first) and a strobe for the
// cycle in which READ_CLK is about to fall.
module readout_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic enable_i,
   output logic readClk_o,
   output logic fall_o
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] divCnt_q, divCnt_d;
   logic       readClk_q, readClk_d;

   // Parking the counter at its terminal value makes the first enabled edge raise the clock.
   always_comb begin
      divCnt_d  = divCnt_q;
      readClk_d = readClk_q;
      if (!enable_i) begin
         divCnt_d  = DIV_LAST;
         readClk_d = 1'b0;
      end else if (divCnt_q == DIV_LAST) begin
         divCnt_d  = '0;
         readClk_d = ~readClk_q;
      end else begin
         divCnt_d = divCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         divCnt_q  <= DIV_LAST;
         readClk_q <= 1'b0;
      end else begin
         divCnt_q  <= divCnt_d;
         readClk_q <= readClk_d;
      end
   end

   assign readClk_o = readClk_q;
   assign fall_o    = readClk_q && (divCnt_q == DIV_LAST);

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchroniser cell for asynchronous single-bit inputs.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/microroc_readout.sv
// Microroc digital RAM readout: drives the chip readout pins, deserialises DOUT
// into 16-bit words for the USB FIFO and reports completion to the DAQ controller.
module microroc_readout
   import daq_readout_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int START_PULSE = 4
) (
   input  logic              Clk_i,
   input  logic              reset_i,
   input  logic              StartReadout_i,
   output logic              EndReadout_o,
   output logic              Busy_o,
   output logic              START_READOUT_o,
   output logic              READ_CLK_o,
   input  logic              TRANSMITON_i,
   input  logic              DOUT_i,
   input  logic              END_READOUT_i,
   input  logic [WORD_W-1:0] ReadoutTimeout_i,
   output logic [WORD_W-1:0] DataOut_o,
   output logic              DataValid_o,
   input  logic              FifoFull_i,
   output logic [WORD_W-1:0] WordCount_o,
   output logic              Overflow_o,
   output logic              TimeoutFlag_o
);

   localparam logic [7:0]          PULSE_LAST = 8'(START_PULSE - 1);
   localparam logic [BITCNT_W-1:0] LAST_BIT   = BITCNT_W'(WORD_W - 1);

   state_e               state_q, state_d;
   logic [7:0]           pulseCnt_q, pulseCnt_d;
   logic [WORD_W-1:0]    shift_q, shift_d;
   logic [BITCNT_W-1:0]  bitCnt_q, bitCnt_d;
   logic [TIMER_W-1:0]   timeCnt_q, timeCnt_d;
   logic [WORD_W-1:0]    dataOut_q, dataOut_d;
   logic                 dataValid_q, dataValid_d;
   logic [WORD_W-1:0]    wordCount_q, wordCount_d;
   logic                 overflow_q, overflow_d;
   logic                 timeoutFlag_q, timeoutFlag_d;
   logic                 endPrev_q;
   logic                 endEdge_q, endEdge_d;

   logic                 txSync, doutSync, endSync;
   logic                 readFall;
   logic                 timeoutHit;
   logic                 writeReq;
   logic [WORD_W-1:0]    writeWord;

   sync_2ff #(.RESET_VAL(1'b1)) uTxSync (
      .clk_i(Clk_i), .reset_i(reset_i), .d_i(TRANSMITON_i), .q_o(txSync)
   );

   sync_2ff #(.RESET_VAL(1'b0)) uDoutSync (
      .clk_i(Clk_i), .reset_i(reset_i), .d_i(DOUT_i), .q_o(doutSync)
   );

   sync_2ff #(.RESET_VAL(1'b0)) uEndSync (
      .clk_i(Clk_i), .reset_i(reset_i), .d_i(END_READOUT_i), .q_o(endSync)
   );

   // Enabled from the next-state so READ_CLK is already high in the first READ cycle.
   readout_clk_gen #(.CLK_DIV(CLK_DIV)) uClkGen (
      .clk_i    (Clk_i),
      .reset_i  (reset_i),
      .enable_i (state_d == READ),
      .readClk_o(READ_CLK_o),
      .fall_o   (readFall)
   );

   assign endEdge_d  = endSync & ~endPrev_q;
   assign timeoutHit = (ReadoutTimeout_i != '0) &&
                       (timeCnt_q[TIMEOUT_SHIFT +: WORD_W] == ReadoutTimeout_i);

   always_comb begin
      state_d       = state_q;
      pulseCnt_d    = pulseCnt_q;
      shift_d       = shift_q;
      bitCnt_d      = bitCnt_q;
      timeCnt_d     = timeCnt_q;
      dataOut_d     = dataOut_q;
      dataValid_d   = 1'b0;
      wordCount_d   = wordCount_q;
      overflow_d    = overflow_q;
      timeoutFlag_d = timeoutFlag_q;
      writeReq      = 1'b0;
      writeWord     = '0;

      case (state_q)
         IDLE: begin
            if (StartReadout_i) begin
               state_d       = START;
               pulseCnt_d    = '0;
               shift_d       = '0;
               bitCnt_d      = '0;
               wordCount_d   = '0;
               overflow_d    = 1'b0;
               timeoutFlag_d = 1'b0;
            end
         end
         START: begin
            if (pulseCnt_q == PULSE_LAST) begin
               state_d   = READ;
               timeCnt_d = '0;
            end else begin
               pulseCnt_d = pulseCnt_q + 8'd1;
            end
         end
         READ: begin
            timeCnt_d = timeCnt_q + 1'b1;
            // A bit landing together with the end edge is still taken before flushing.
            if (readFall && !txSync) begin
               shift_d = {shift_q[WORD_W-2:0], doutSync};
               if (bitCnt_q == LAST_BIT) begin
                  writeReq  = 1'b1;
                  writeWord = shift_d;
                  bitCnt_d  = '0;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end
            if (endEdge_q) begin
               state_d = FLUSH;
            end else if (timeoutHit) begin
               state_d       = FLUSH;
               timeoutFlag_d = 1'b1;
            end
         end
         FLUSH: begin
            if (bitCnt_q != '0) begin
               writeReq  = 1'b1;
               writeWord = leftAlign(shift_q, bitCnt_q);
            end
            bitCnt_d = '0;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (writeReq) begin
         if (FifoFull_i) begin
            overflow_d = 1'b1;
         end else begin
            dataOut_d   = writeWord;
            dataValid_d = 1'b1;
            if (wordCount_q != '1) begin
               wordCount_d = wordCount_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         pulseCnt_q    <= '0;
         shift_q       <= '0;
         bitCnt_q      <= '0;
         timeCnt_q     <= '0;
         dataOut_q     <= '0;
         dataValid_q   <= 1'b0;
         wordCount_q   <= '0;
         overflow_q    <= 1'b0;
         timeoutFlag_q <= 1'b0;
         endPrev_q     <= 1'b0;
         endEdge_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pulseCnt_q    <= pulseCnt_d;
         shift_q       <= shift_d;
         bitCnt_q      <= bitCnt_d;
         timeCnt_q     <= timeCnt_d;
         dataOut_q     <= dataOut_d;
         dataValid_q   <= dataValid_d;
         wordCount_q   <= wordCount_d;
         overflow_q    <= overflow_d;
         timeoutFlag_q <= timeoutFlag_d;
         endPrev_q     <= endSync;
         endEdge_q     <= endEdge_d;
      end
   end

   assign START_READOUT_o = (state_q == START);
   assign EndReadout_o    = (state_q == DONE);
   assign Busy_o          = (state_q != IDLE);
   assign DataOut_o       = dataOut_q;
   assign DataValid_o     = dataValid_q;
   assign WordCount_o     = wordCount_q;
   assign Overflow_o      = overflow_q;
   assign TimeoutFlag_o   = timeoutFlag_q;

endmodule

// File: tb/tb_microroc_readout.sv
// Directed bench for microroc_readout: a behavioural chip drives DOUT on READ_CLK
// rising edges; every check compares against hand-computed values.
module tb_microroc_readout;

   localparam int CLK_DIV     = 4;
   localparam int START_PULSE = 4;

   logic        Clk          = 1'b0;
   logic        reset        = 1'b1;
   logic        StartReadout = 1'b0;
   logic        TRANSMITON   = 1'b1;
   logic        DOUT         = 1'b0;
   logic        END_READOUT  = 1'b0;
   logic        FifoFull     = 1'b0;
   logic [15:0] ReadoutTimeout = 16'd0;

   logic        EndReadout_o, Busy_o, START_READOUT_o, READ_CLK_o;
   logic [15:0] DataOut_o, WordCount_o;
   logic        DataValid_o, Overflow_o, TimeoutFlag_o;

   int testsRun    = 0;
   int testsFailed = 0;
   int startHigh   = 0;
   int endPulses   = 0;
   int cycleNow    = 0;
   logic [15:0] words[$];

   always #5 Clk = ~Clk;

   microroc_readout #(.CLK_DIV(CLK_DIV), .START_PULSE(START_PULSE)) dut (
      .Clk_i           (Clk),
      .reset_i         (reset),
      .StartReadout_i  (StartReadout),
      .EndReadout_o    (EndReadout_o),
      .Busy_o          (Busy_o),
      .START_READOUT_o (START_READOUT_o),
      .READ_CLK_o      (READ_CLK_o),
      .TRANSMITON_i    (TRANSMITON),
      .DOUT_i          (DOUT),
      .END_READOUT_i   (END_READOUT),
      .ReadoutTimeout_i(ReadoutTimeout),
      .DataOut_o       (DataOut_o),
      .DataValid_o     (DataValid_o),
      .FifoFull_i      (FifoFull),
      .WordCount_o     (WordCount_o),
      .Overflow_o      (Overflow_o),
      .TimeoutFlag_o   (TimeoutFlag_o)
   );

   // Records FIFO writes and pulse activity away from the active edge.
   always @(negedge Clk) begin
      if (DataValid_o === 1'b1) words.push_back(DataOut_o);
      if (EndReadout_o === 1'b1) endPulses++;
      if (START_READOUT_o === 1'b1) startHigh++;
   end

   always @(posedge Clk) cycleNow++;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [15:0] wordAt(input int idx);
      if (idx >= 0 && idx < words.size()) return words[idx];
      return 'x;
   endfunction

   task automatic applyStimulus();
      StartReadout = 1'b1;
      tick(1);
      StartReadout = 1'b0;
   endtask

   // Chip model: presents the next bit after each READ_CLK rising edge.
   task automatic sendBits(input logic [31:0] data, input int n, input int fullFromBit);
      logic lastRc;
      logic found;
      TRANSMITON = 1'b0;
      lastRc = READ_CLK_o;
      for (int i = 0; i < n; i++) begin
         found = 1'b0;
         for (int k = 0; k < 200 && !found; k++) begin
            tick(1);
            found  = READ_CLK_o && !lastRc;
            lastRc = READ_CLK_o;
         end
         if (!found) begin
            checkOutput("readClkRise", 32'(found), 32'd1);
            return;
         end
         DOUT = data[n-1-i];
         if (i == fullFromBit) FifoFull = 1'b1;
      end
   endtask

   // Lets the last bit be sampled, raises END_READOUT and measures EndReadout latency.
   task automatic endChip(output int lat);
      logic found;
      for (int k = 0; k < 50 && READ_CLK_o; k++) tick(1);
      tick(2);
      TRANSMITON  = 1'b1;
      END_READOUT = 1'b1;
      lat   = -1;
      found = 1'b0;
      for (int k = 1; k <= 20 && !found; k++) begin
         tick(1);
         if (EndReadout_o) begin
            lat   = k;
            found = 1'b1;
         end
      end
      END_READOUT = 1'b0;
   endtask

   initial begin
      int base, sh, ep, lat, t0, t1;
      logic found;

      // Power-up reset held for three cycles.
      tick(1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("rstReadClkStatic", 32'(READ_CLK_o), 32'd0);
         tick(1);
      end
      checkOutput("rstCtrl", 32'({EndReadout_o, Busy_o, START_READOUT_o, READ_CLK_o,
                                  DataValid_o, Overflow_o, TimeoutFlag_o}), 32'd0);
      checkOutput("rstData", {DataOut_o, WordCount_o}, 32'd0);
      reset = 1'b0;
      tick(3);

      // Normal two-word readout.
      base = words.size(); sh = startHigh; ep = endPulses;
      applyStimulus();
      checkOutput("normBusy", 32'(Busy_o), 32'd1);
      checkOutput("normStartPinRise", 32'(START_READOUT_o), 32'd1);
      sendBits(32'hA5A53C3C, 32, -1);
      endChip(lat);
      tick(3);
      checkOutput("normStartHigh", 32'(startHigh - sh), 32'(START_PULSE));
      checkOutput("normWords", 32'(words.size() - base), 32'd2);
      checkOutput("normWord0", 32'(wordAt(base)), 32'hA5A5);
      checkOutput("normWord1", 32'(wordAt(base + 1)), 32'h3C3C);
      checkOutput("normWordCount", 32'(WordCount_o), 32'd2);
      checkOutput("normEndLatency", 32'(lat), 32'd5);
      checkOutput("normEndPulses", 32'(endPulses - ep), 32'd1);
      checkOutput("normBusyAfter", 32'(Busy_o), 32'd0);
      checkOutput("normDataHeld", 32'(DataOut_o), 32'h3C3C);

      // FIFO full while the second word completes.
      base = words.size();
      applyStimulus();
      sendBits(32'hA5A53C3C, 32, 16);
      endChip(lat);
      FifoFull = 1'b0;
      tick(3);
      checkOutput("fullWords", 32'(words.size() - base), 32'd1);
      checkOutput("fullWord0", 32'(wordAt(base)), 32'hA5A5);
      checkOutput("fullOverflow", 32'(Overflow_o), 32'd1);
      checkOutput("fullWordCount", 32'(WordCount_o), 32'd1);

      // Partial word padded on flush; start clears the sticky overflow.
      base = words.size();
      applyStimulus();
      checkOutput("ovfClearedOnStart", 32'(Overflow_o), 32'd0);
      checkOutput("cntClearedOnStart", 32'(WordCount_o), 32'd0);
      sendBits(32'h000ABCDE, 20, -1);
      endChip(lat);
      tick(3);
      checkOutput("partWords", 32'(words.size() - base), 32'd2);
      checkOutput("partWord0", 32'(wordAt(base)), 32'hABCD);
      checkOutput("partWord1", 32'(wordAt(base + 1)), 32'hE000);
      checkOutput("partWordCount", 32'(WordCount_o), 32'd2);

      // Reset in idle clears counters, data and flags.
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checkOutput("idleRstReadClk", 32'(READ_CLK_o), 32'd0);
      end
      checkOutput("idleRstCtrl", 32'({EndReadout_o, Busy_o, START_READOUT_o, READ_CLK_o,
                                      DataValid_o, Overflow_o, TimeoutFlag_o}), 32'd0);
      checkOutput("idleRstData", {DataOut_o, WordCount_o}, 32'd0);
      reset = 1'b0;
      tick(2);

      // Timeout after 2*256 cycles, with an ignored start request mid-readout.
      ReadoutTimeout = 16'd2;
      sh = startHigh; ep = endPulses;
      applyStimulus();
      t0 = -1;
      for (int k = 0; k < 20 && t0 < 0; k++) begin
         tick(1);
         if (READ_CLK_o) t0 = cycleNow;
      end
      checkOutput("toReadEntry", 32'(t0 >= 0), 32'd1);
      tick(20);
      applyStimulus();
      tick(2);
      checkOutput("ignStartPulse", 32'(startHigh - sh), 32'(START_PULSE));
      checkOutput("ignStillBusy", 32'(Busy_o), 32'd1);
      t1 = -1;
      for (int k = 0; k < 1000 && t1 < 0; k++) begin
         if (EndReadout_o) t1 = cycleNow;
         else tick(1);
      end
      checkOutput("toLatency", 32'(t1 - t0), 32'd514);
      checkOutput("toFlag", 32'(TimeoutFlag_o), 32'd1);
      tick(2);
      checkOutput("toEndPulses", 32'(endPulses - ep), 32'd1);

      // Timeout disabled: stays in READ well past 512 cycles, ends by END_READOUT.
      ReadoutTimeout = 16'd0;
      ep = endPulses;
      applyStimulus();
      checkOutput("toFlagCleared", 32'(TimeoutFlag_o), 32'd0);
      tick(1500);
      checkOutput("noToBusy", 32'(Busy_o), 32'd1);
      checkOutput("noToNoEnd", 32'(endPulses - ep), 32'd0);
      endChip(lat);
      checkOutput("noToEndLatency", 32'(lat), 32'd5);
      checkOutput("noToFlag", 32'(TimeoutFlag_o), 32'd0);
      tick(3);

      // Reset after 7 bits discards the partial word without reporting completion.
      base = words.size(); ep = endPulses;
      applyStimulus();
      sendBits(32'h0000005B, 7, -1);
      tick(6);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checkOutput("midRstBusy", 32'(Busy_o), 32'd0);
      checkOutput("midRstReadClk", 32'(READ_CLK_o), 32'd0);
      TRANSMITON = 1'b1;
      tick(20);
      checkOutput("midRstNoWord", 32'(words.size() - base), 32'd0);
      checkOutput("midRstNoEnd", 32'(endPulses - ep), 32'd0);
      checkOutput("midRstReadClkIdle", 32'(READ_CLK_o), 32'd0);

      // A fresh readout after the reset starts word alignment from scratch.
      base = words.size();
      applyStimulus();
      sendBits(32'h00001234, 16, -1);
      endChip(lat);
      tick(3);
      checkOutput("postRstWords", 32'(words.size() - base), 32'd1);
      checkOutput("postRstWord0", 32'(wordAt(base)), 32'h1234);

      found = 1'b1;
      if (found) $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
